dm_load_store_unit: RTL and testbench

Data-memory access unit for the datapath's memory stage. It accepts one load or store per request from execute, using `alu_out` as the byte address. Stores are written into an internal word-organised data memory with byte enables. Loads are read, aligned and sign- or zero-extended onto `dataR`, which is the memory input of the writeback select mux (`dataR` / `alu_out` / `pc_plus_4`).

---
 rtl/dm_load_store_unit.sv | 137 +++++++++++++
 tb/tb_dm_load_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dm_load_store_unit.sv
// Memory-stage load/store unit: word-organised data memory with byte-lane stores
// and aligned, sign/zero-extended loads. Optional misalignment trap: DM_MISALIGN_TRAP_EN.
module dm_load_store_unit #(
  parameter int width = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [width-1:0] alu_out,
  input  logic [width-1:0] store_data,
  output logic [width-1:0] dataR,
  output logic             rsp_valid,
  output logic             misalign
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

  state_t           state, state_nxt;
  logic [width-1:0] mem [DEPTH];
  logic             accept;
  logic             trap;
  logic [AW-1:0]    idx;
  logic [3:0]       be;
  logic [width-1:0] wdata;
  logic [AW-1:0]    idx_p0;
  logic [1:0]       off_p0;
  logic [2:0]       funct3_p0;
  logic             unused_addr_bits;

  function automatic logic [3:0] byte_en(input logic [2:0] f, input logic [1:0] off);
    case (f[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [width-1:0] store_lanes(input logic [2:0] f, input logic [width-1:0] d);
    case (f[1:0])
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Shift the addressed lane(s) down to bit 0 and extend; f[2] selects zero-extension.
  function automatic logic [width-1:0] load_align(input logic [width-1:0] word,
                                                   input logic [2:0] f, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f[1:0])
      2'b00:   load_align = f[2] ? {{(width-8){1'b0}}, b}  : {{(width-8){b[7]}}, b};
      2'b01:   load_align = f[2] ? {{(width-16){1'b0}}, h} : {{(width-16){h[15]}}, h};
      default: load_align = word;
    endcase
  endfunction

`ifdef DM_MISALIGN_TRAP_EN
  logic mis_p0;

  function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] off);
    is_misaligned = ((f[1:0] == 2'b01) && off[0]) || (f[1] && (off != 2'b00));
  endfunction

  assign trap = is_misaligned(funct3, alu_out[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept           = req_valid && req_ready;
  assign idx              = alu_out[AW+1:2];
  assign be               = byte_en(funct3, alu_out[1:0]);
  assign wdata            = store_lanes(funct3, store_data);
  assign unused_addr_bits = ^alu_out[width-1:AW+2];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (mem_write || trap) ? RESP : LOAD;
      LOAD:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
`ifdef DM_MISALIGN_TRAP_EN
    misalign  = (state == RESP) && mis_p0;
`else
    misalign  = 1'b0;
`endif
  end

  // Stage p0: request capture at acceptance; stores commit on the same edge
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0    <= idx;
      off_p0    <= alu_out[1:0];
      funct3_p0 <= funct3;
    end
    if (accept && mem_write && !trap && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage p1: state and load result registered on LOAD->RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dataR <= '0;
`ifdef DM_MISALIGN_TRAP_EN
      mis_p0 <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == LOAD) dataR <= load_align(mem[idx_p0], funct3_p0, off_p0);
`ifdef DM_MISALIGN_TRAP_EN
      if (accept) begin
        mis_p0 <= trap;
        if (trap) dataR <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Self-checking bench for dm_load_store_unit: directed plan steps plus random
// accesses against a byte-addressed reference memory.
module tb_dm_load_store_unit;
  localparam int DEPTH = 1024;
  localparam int MB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [31:0] dataR;
  logic        rsp_valid;
  logic        misalign;

  int          errors = 0;
  int          checks = 0;
  bit   [7:0]  mb [MB];
  bit   [31:0] last_dr = '0;

  dm_load_store_unit #(.width(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .funct3(funct3), .alu_out(alu_out),
    .store_data(store_data), .dataR(dataR), .rsp_valid(rsp_valid),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input bit [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference: little-endian byte memory of 4*DEPTH bytes; returns trap flag and expected dataR.
  task automatic model(input bit mw, input bit [2:0] f, input bit [31:0] addr,
                       input bit [31:0] sd, output bit trap, output bit [31:0] rd);
    int n = size_of(f);
    int a = int'(addr % MB);
    trap = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    trap = (addr % n) != 0;
`endif
    a = a - (a % n);
    rd = last_dr;
    if (trap) begin
      rd = '0;
      last_dr = rd;
    end else if (mw) begin
      for (int i = 0; i < n; i++) mb[a+i] = sd[8*i +: 8];
    end else begin
      rd = '0;
      for (int i = 0; i < n; i++) rd = rd | (32'(mb[a+i]) << (8*i));
      if (n < 4 && !f[2] && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      last_dr = rd;
    end
  endtask

  // One complete access from IDLE through the end of its RESP cycle.
  task automatic access(input bit mw, input bit [2:0] f, input bit [31:0] addr, input bit [31:0] sd);
    bit        trap;
    bit [31:0] rd;
    bit [31:0] prev_dr;
    prev_dr = last_dr;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; mem_write = mw; funct3 = f; alu_out = addr; store_data = sd;
    model(mw, f, addr, sd, trap, rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_write = 1'($urandom); funct3 = 3'($urandom); alu_out = $urandom; store_data = $urandom;
    if (!mw && !trap) begin
      chk("load_busy_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("load_busy_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("resp_ready", {31'b0, req_ready}, 32'd0);
    chk("misalign", {31'b0, misalign}, {31'b0, trap});
    if (mw && !trap) chk("store_dataR_hold", dataR, prev_dr);
    else             chk("dataR", dataR, rd);
    @(posedge clk); #1;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    bit        t;
    bit [31:0] rd;
    bit [31:0] a;
    bit [2:0]  f;
    reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0; funct3 = '0; alu_out = '0; store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rst_dataR", dataR, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    reset = 1'b0;

    // Initialise the region the random phase reads from.
    for (int w = 0; w < 32; w++) access(1'b1, 3'b010, 32'(w * 4), $urandom);

    access(1'b1, 3'b010, 32'h10, 32'hAAAA_AAAA);
    access(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_aaaa", dataR, 32'hAAAA_AAAA);

    access(1'b1, 3'b010, 32'h10, 32'h1234_5678);
    access(1'b1, 3'b000, 32'h13, 32'hFFFF_FF55);
    access(1'b0, 3'b010, 32'h10, 32'h0);
    chk("sb_merge", dataR, 32'h5534_5678);
    access(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_13", dataR, 32'h0000_0055);
    access(1'b0, 3'b100, 32'h11, 32'h0);
    chk("lbu_11", dataR, 32'h0000_0056);

    access(1'b1, 3'b001, 32'h22, 32'h0000_8765);
    access(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_22", dataR, 32'hFFFF_8765);
    access(1'b0, 3'b101, 32'h22, 32'h0);
    chk("lhu_22", dataR, 32'h0000_8765);

    // Address wrap with req_valid held high through RESP.
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; alu_out = 32'(MB + 8); store_data = 32'hC0DE_F00D;
    model(1'b1, 3'b010, 32'(MB + 8), 32'hC0DE_F00D, t, rd);
    @(posedge clk); #1;
    chk("hold_store_rsp", {31'b0, rsp_valid}, 32'd1);
    mem_write = 1'b0; alu_out = 32'h8;
    model(1'b0, 3'b010, 32'h8, 32'h0, t, rd);
    @(posedge clk); #1;
    chk("hold_not_in_resp", {31'b0, rsp_valid}, 32'd0);
    chk("hold_idle_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("hold_accepted", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("wrap_data", dataR, 32'hC0DE_F00D);
    chk("wrap_model", dataR, rd);
    @(posedge clk); #1;

    // Reset during LOAD: no response, dataR cleared.
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_out = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("rl_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rl_dataR", dataR, 32'd0);
    chk("rl_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    last_dr = '0;
    @(posedge clk); #1;
    chk("rl_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Misaligned word accesses (trap or aligned-down depending on build).
    access(1'b0, 3'b010, 32'h12, 32'h0);
    access(1'b1, 3'b010, 32'h12, 32'hDEAD_BEEF);
    access(1'b0, 3'b010, 32'h10, 32'h0);

    for (int k = 0; k < 300; k++) begin
      f = 3'($urandom);
      a = 32'($urandom_range(0, 127)) + 32'($urandom_range(0, 7)) * 32'(MB);
      access(1'($urandom), f, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
